// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the two writeback requesters (A: ALU, B: load return), the
// write arbiter and the regfile write port. The arbiter uses the master view.
interface regfile_write_arbiter_if;
    logic        a_valid;
    logic [2:0]  a_num;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_num;
    logic [15:0] b_data;
    logic        b_ready;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] writedata;
    logic        squash;
    logic [7:0]  pend_mask;

    modport master (
        input  a_valid, a_num, a_data, b_valid, b_num, b_data,
        output a_ready, b_ready, write, writenum, writedata, squash, pend_mask
    );

    modport slave (
        output a_valid, a_num, a_data, b_valid, b_num, b_data,
        input  a_ready, b_ready, write, writenum, writedata, squash, pend_mask
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the single regfile write port with a registered
// output stage and a pending-write mask. Optional B anti-starvation: WRARB_FAIRNESS_EN.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    regfile_write_arbiter_if.master        wr_if
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic        b_prio;
    logic        a_ready;
    logic        b_ready;
    logic        a_fire;
    logic        b_fire;

    logic        write_q,     write_d;
    logic [2:0]  writenum_q,  writenum_d;
    logic [15:0] writedata_q, writedata_d;
    logic        squash_q,    squash_d;

`ifdef WRARB_FAIRNESS_EN
    logic [2:0]  starve_q, starve_d;

    always_comb begin
        b_prio   = wr_if.b_valid && (starve_q == LIMIT);
        starve_d = starve_q;
        if (b_fire) begin
            starve_d = 3'd0;
        end else if (wr_if.b_valid && (starve_q != LIMIT)) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q <= 3'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^LIMIT;
    assign b_prio       = 1'b0;
`endif

    // A wins unless B is starved; a same-register B is retired alongside A
    // because A is younger and overwrites it anyway.
    always_comb begin
        a_ready = rst && wr_if.a_valid && !b_prio;
        b_ready = rst && wr_if.b_valid &&
                  (b_prio || !wr_if.a_valid || (wr_if.a_num == wr_if.b_num));
        a_fire  = wr_if.a_valid && a_ready;
        b_fire  = wr_if.b_valid && b_ready;
    end

    always_comb begin
        write_d     = 1'b0;
        writenum_d  = writenum_q;
        writedata_d = writedata_q;
        squash_d    = a_fire && b_fire;
        if (a_fire) begin
            write_d     = 1'b1;
            writenum_d  = wr_if.a_num;
            writedata_d = wr_if.a_data;
        end else if (b_fire) begin
            write_d     = 1'b1;
            writenum_d  = wr_if.b_num;
            writedata_d = wr_if.b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            write_q     <= 1'b0;
            writenum_q  <= 3'd0;
            writedata_q <= 16'd0;
            squash_q    <= 1'b0;
        end else begin
            write_q     <= write_d;
            writenum_q  <= writenum_d;
            writedata_q <= writedata_d;
            squash_q    <= squash_d;
        end
    end

    assign wr_if.a_ready   = a_ready;
    assign wr_if.b_ready   = b_ready;
    assign wr_if.write     = write_q;
    assign wr_if.writenum  = writenum_q;
    assign wr_if.writedata = writedata_q;
    assign wr_if.squash    = squash_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pend
        assign wr_if.pend_mask[gi] =
            (wr_if.a_valid && (wr_if.a_num == 3'(gi))) ||
            (wr_if.b_valid && (wr_if.b_num == 3'(gi))) ||
            (write_q       && (writenum_q  == 3'(gi)));
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst;
    regfile_write_arbiter_if ifc();

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (checked on every falling edge) ----------
    bit          m_known = 0;
    bit          m_write;
    logic [2:0]  m_num;
    logic [15:0] m_data;
    bit          m_squash;
    int          m_wait = 0;
    logic [7:0]  exp_mask;
    bit          starved, ga, gb;

    always @(negedge clk) begin
        if (m_known) begin
            chk("write",     32'(ifc.write),     32'(m_write));
            chk("writenum",  32'(ifc.writenum),  32'(m_num));
            chk("writedata", 32'(ifc.writedata), 32'(m_data));
            chk("squash",    32'(ifc.squash),    32'(m_squash));
            exp_mask = 8'd0;
            if (ifc.a_valid) exp_mask[ifc.a_num] = 1'b1;
            if (ifc.b_valid) exp_mask[ifc.b_num] = 1'b1;
            if (m_write)     exp_mask[m_num]     = 1'b1;
            chk("pend_mask", 32'(ifc.pend_mask), 32'(exp_mask));
        end
        starved = 0;
`ifdef WRARB_FAIRNESS_EN
        starved = ifc.b_valid && (m_wait == LIMIT);
`endif
        ga = 0;
        gb = 0;
        if (rst) begin
            if (starved) gb = 1;
            else if (ifc.a_valid) begin
                ga = 1;
                gb = ifc.b_valid && (ifc.a_num == ifc.b_num);
            end else gb = ifc.b_valid;
        end
        if (ifc.a_valid) chk("a_ready", 32'(ifc.a_ready), 32'(ga));
        if (ifc.b_valid) chk("b_ready", 32'(ifc.b_ready), 32'(gb));
        if (!rst) begin
            m_write = 0; m_num = 3'd0; m_data = 16'd0; m_squash = 0; m_wait = 0;
            m_known = 1;
        end else begin
            m_squash = ga && gb;
            if (ga) begin
                m_write = 1; m_num = ifc.a_num; m_data = ifc.a_data;
            end else if (gb) begin
                m_write = 1; m_num = ifc.b_num; m_data = ifc.b_data;
            end else begin
                m_write = 0;
            end
            if (gb) m_wait = 0;
            else if (ifc.b_valid && m_wait < LIMIT) m_wait++;
        end
    end

    // ---------------- stimulus and literal expectations ------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit a_acc, b_acc, a_new;
    int wr_cnt, b_seen;

    initial begin
        rst = 1'b0;
        ifc.a_valid = 1'b1; ifc.a_num = 3'd3; ifc.a_data = 16'h1234;
        ifc.b_valid = 1'b0; ifc.b_num = 3'd0; ifc.b_data = 16'h0000;
        #1;
        chk("rst_a_ready", 32'(ifc.a_ready), 32'd0);
        step();
        step();
        chk("rst_write",     32'(ifc.write),     32'd0);
        chk("rst_writenum",  32'(ifc.writenum),  32'd0);
        chk("rst_writedata", 32'(ifc.writedata), 32'd0);
        chk("rst_squash",    32'(ifc.squash),    32'd0);
        chk("rst_a_ready2",  32'(ifc.a_ready),   32'd0);
        rst = 1'b1;
        #1;
        chk("rel_a_ready", 32'(ifc.a_ready), 32'd1);
        step();
        ifc.a_valid = 1'b0;
        #1;
        chk("rel_write",     32'(ifc.write),     32'd1);
        chk("rel_writenum",  32'(ifc.writenum),  32'd3);
        chk("rel_writedata", 32'(ifc.writedata), 32'h1234);

        // A and B to different registers
        step();
        ifc.a_valid = 1'b1; ifc.a_num = 3'd1; ifc.a_data = 16'hAAAA;
        ifc.b_valid = 1'b1; ifc.b_num = 3'd2; ifc.b_data = 16'h5555;
        #1;
        chk("diff_c0_a_ready", 32'(ifc.a_ready),   32'd1);
        chk("diff_c0_b_ready", 32'(ifc.b_ready),   32'd0);
        chk("diff_c0_mask",    32'(ifc.pend_mask), 32'h06);
        step();
        ifc.a_valid = 1'b0;
        #1;
        chk("diff_c1_write",   32'(ifc.write),     32'd1);
        chk("diff_c1_num",     32'(ifc.writenum),  32'd1);
        chk("diff_c1_data",    32'(ifc.writedata), 32'hAAAA);
        chk("diff_c1_b_ready", 32'(ifc.b_ready),   32'd1);
        chk("diff_c1_mask",    32'(ifc.pend_mask), 32'h06);
        step();
        ifc.b_valid = 1'b0;
        #1;
        chk("diff_c2_num",  32'(ifc.writenum),  32'd2);
        chk("diff_c2_data", 32'(ifc.writedata), 32'h5555);
        step();
        chk("idle_write", 32'(ifc.write), 32'd0);

        // same-destination collision
        ifc.a_valid = 1'b1; ifc.a_num = 3'd4; ifc.a_data = 16'h0001;
        ifc.b_valid = 1'b1; ifc.b_num = 3'd4; ifc.b_data = 16'hFFFF;
        #1;
        chk("col_a_ready", 32'(ifc.a_ready), 32'd1);
        chk("col_b_ready", 32'(ifc.b_ready), 32'd1);
        step();
        ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
        #1;
        chk("col_write",  32'(ifc.write),     32'd1);
        chk("col_data",   32'(ifc.writedata), 32'h0001);
        chk("col_squash", 32'(ifc.squash),    32'd1);
        step();
        chk("col_squash_end", 32'(ifc.squash), 32'd0);
        chk("col_write_end",  32'(ifc.write),  32'd0);

        // continuous A traffic with B waiting on R6
        ifc.b_valid = 1'b1; ifc.b_num = 3'd6; ifc.b_data = 16'hBEEF;
        a_new = 1; wr_cnt = 0; b_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (a_new) begin
                ifc.a_valid = 1'b1; ifc.a_num = 3'(k % 4); ifc.a_data = 16'h0100 + 16'(k);
            end
            #1;
`ifdef WRARB_FAIRNESS_EN
            chk("fair_b_ready", 32'(ifc.b_ready), 32'(k == 4));
            chk("fair_a_ready", 32'(ifc.a_ready), 32'(k != 4));
`else
            if (ifc.b_ready) b_seen++;
`endif
            a_new = ifc.a_ready;
            b_acc = ifc.b_valid && ifc.b_ready;
            step();
            if (b_acc) ifc.b_valid = 1'b0;
            if (ifc.write) wr_cnt++;
`ifdef WRARB_FAIRNESS_EN
            if (k == 4) begin
                chk("fair_b_num",  32'(ifc.writenum),  32'd6);
                chk("fair_b_data", 32'(ifc.writedata), 32'hBEEF);
            end
`endif
        end
        chk("stream_writes", 32'(wr_cnt), 32'd20);
`ifndef WRARB_FAIRNESS_EN
        chk("nofair_b_ready_seen", 32'(b_seen), 32'd0);
`endif
        ifc.a_valid = 1'b0;
        #1;
        step();
        ifc.b_valid = 1'b0;
        step();

        // mid-operation reset
        ifc.a_valid = 1'b1; ifc.a_num = 3'd5; ifc.a_data = 16'h7777;
        #1;
        chk("mid_a_ready", 32'(ifc.a_ready), 32'd1);
        step();
        ifc.a_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("mid_write",    32'(ifc.write),    32'd0);
        chk("mid_writenum", 32'(ifc.writenum), 32'd0);
        rst = 1'b1;
        step();

        // randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if (!ifc.a_valid && $urandom_range(3) != 0) begin
                ifc.a_valid = 1'b1; ifc.a_num = 3'($urandom); ifc.a_data = 16'($urandom);
            end
            if (!ifc.b_valid && $urandom_range(1) != 0) begin
                ifc.b_valid = 1'b1; ifc.b_num = 3'($urandom); ifc.b_data = 16'($urandom);
            end
            rst = ($urandom_range(40) != 0);
            #1;
            a_acc = ifc.a_valid && ifc.a_ready;
            b_acc = ifc.b_valid && ifc.b_ready;
            step();
            if (a_acc) ifc.a_valid = 1'b0;
            if (b_acc) ifc.b_valid = 1'b0;
        end
        rst = 1'b1;
        ifc.a_valid = 1'b0; ifc.b_valid = 1'b0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
